sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO. Successor to the fixed-configuration FIFO used in the FIFO test design.
- Adds generic width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow flags.
- An optional first-word-fall-through (FWFT) read mode is selected by macro.
- Sits between a 200 MHz data producer and consumer inside fifo_test-style designs, driven by the single-ended system clock after the differential buffer.

---
 rtl/sync_fifo_param.sv | 119 +++++++++++
 tb/tb_sync_fifo_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost flags, occupancy count and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   data_count,
  output logic              wr_ack,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = CW'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic              pop;
  logic              empty_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Total occupancy after this edge
  always_comb begin
    cnt_nxt = data_count;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = data_count + CW'(1);
      2'b01:   cnt_nxt = data_count - CW'(1);
      default: cnt_nxt = data_count;
    endcase
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Words still in the array, excluding the one held on dout
  logic [ADDR_W:0] mem_cnt;
  logic [ADDR_W:0] mem_cnt_nxt;

  // Refill the output stage when it is empty or being consumed
  assign pop       = (mem_cnt != '0) && (empty || rd_acc);
  assign empty_nxt = !(pop || (!empty && !rd_acc));

  always_comb begin
    mem_cnt_nxt = mem_cnt;
    case ({wr_acc, pop})
      2'b10:   mem_cnt_nxt = mem_cnt + CW'(1);
      2'b01:   mem_cnt_nxt = mem_cnt - CW'(1);
      default: mem_cnt_nxt = mem_cnt;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) mem_cnt <= '0;
    else        mem_cnt <= mem_cnt_nxt;
  end
`else
  assign pop       = rd_acc;
  assign empty_nxt = (cnt_nxt == '0);
`endif

  // Storage array, intentionally not reset
  always_ff @(posedge sys_clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      dout         <= '0;
      data_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_ack       <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      data_count   <= cnt_nxt;
      full         <= (cnt_nxt == DEPTH_C);
      empty        <= empty_nxt;
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      wr_ack       <= wr_acc;
      // A new error in the same cycle as clr_err keeps the flag set
      if (wr_en && full)      overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (rd_en && empty)     underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model with random and directed stimulus.
// Define SYNC_FIFO_FWFT_EN to run the first-word-fall-through directed checks instead.
module tb_sync_fifo_param;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned AF_THRESH = 14;
  localparam int unsigned AE_THRESH = 2;
  localparam int          DEPTH     = 16;

  logic              sys_clk;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   data_count;
  logic              wr_ack;
  logic              overflow;
  logic              underflow;

  int tests_run;
  int tests_failed;

  sync_fifo_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .clr_err(clr_err), .dout(dout), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .data_count(data_count),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then sample 1 time unit after the rising edge
  task automatic drive(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    @(negedge sys_clk);
    wr_en = w; din = d; rd_en = r; clr_err = c;
    @(posedge sys_clk);
    #1;
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  // Reference model: contents as a queue, flags derived from its size
  logic [DATA_W-1:0] q [$];
  logic [DATA_W-1:0] m_dout;
  logic              m_ack;
  logic              m_ovf;
  logic              m_unf;

  task automatic model_reset();
    q.delete();
    m_dout = '0; m_ack = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("dout",         32'(dout),         32'(m_dout));
    check("full",         32'(full),         32'(n == DEPTH));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= int'(AF_THRESH)));
    check("almost_empty", 32'(almost_empty), 32'(n <= int'(AE_THRESH)));
    check("data_count",   32'(data_count),   32'(n));
    check("wr_ack",       32'(wr_ack),       32'(m_ack));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
  endtask

  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    bit full_p, empty_p, wok, rok;
    @(negedge sys_clk);
    wr_en = w; din = d; rd_en = r; clr_err = c;
    @(posedge sys_clk);
    full_p  = (q.size() == DEPTH);
    empty_p = (q.size() == 0);
    wok = w && !full_p;
    rok = r && !empty_p;
    if (rok) m_dout = q.pop_front();
    if (wok) q.push_back(d);
    m_ack = wok;
    if (w && full_p) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && empty_p) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    int ack_seen;
    int wbias;
    logic [DATA_W-1:0] seq;
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; wr_en = 1'b0; din = '0; rd_en = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_all();
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Fill to full
    ack_seen = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DATA_W'(i), 1'b0, 1'b0);
      ack_seen += int'(wr_ack);
    end
    check("ack_pulses", 32'(ack_seen), 32'd16);

    // Overflow, then drain in order, then underflow and clr_err precedence
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Steady state at 8 words with pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(8'h20 + i), 1'b0, 1'b0);
    seq = 8'h28;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, seq, 1'b1, 1'b0);
      seq = seq + 8'd1;
    end

    // Full with simultaneous read: write rejected, read accepted
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'h40 + i), 1'b0, 1'b0);
    @(negedge sys_clk);
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge sys_clk);
    rst_n = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_reset_data", 32'(dout), 32'h77);

    // Randomised traffic with shifting write/read balance
    for (int i = 0; i < 600; i++) begin
      wbias = (i < 200) ? 75 : ((i < 400) ? 25 : 50);
      step(1'($urandom_range(0, 99) < wbias), DATA_W'($urandom),
           1'($urandom_range(0, 99) < (100 - wbias)), 1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
`else
  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; wr_en = 1'b0; din = '0; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(data_count), 32'd0);
    check("rst_dout",  32'(dout), 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Single word falls through without rd_en
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("fwft_dout",  32'(dout), 32'h5A);
    check("fwft_empty", 32'(empty), 32'd0);
    check("fwft_count", 32'(data_count), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("ack_empty", 32'(empty), 32'd1);
    check("ack_count", 32'(data_count), 32'd0);
    check("ack_unf",   32'(underflow), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set",   32'(underflow), 32'd1);
    check("unf_dout",  32'(dout), 32'h5A);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_clr",   32'(underflow), 32'd0);

    // Fill completely, overflow, then drain in order
    for (int i = 0; i < 16; i++) drive(1'b1, DATA_W'(3 * i), 1'b0, 1'b0);
    check("fill_full",  32'(full), 32'd1);
    check("fill_count", 32'(data_count), 32'd16);
    check("fill_af",    32'(almost_full), 32'd1);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_set",    32'(overflow), 32'd1);
    check("ovf_count",  32'(data_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("drain_dout",  32'(dout), 32'(DATA_W'(3 * i)));
      check("drain_empty", 32'(empty), 32'd0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_done",  32'(empty), 32'd1);
    check("drain_count", 32'(data_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
`endif

endmodule
